// File: rtl/parity_frame_checker.sv
// parity_frame_checker: checks frames of FRAME_LEN serial data bits followed by one parity bit
// Ports: clk, reset_n (async, active-low), clear (sync frame abort), x_valid/x (serial input),
//        parity (Mealy running parity), busy (DATA/CHECK), frame_done (1-cycle pulse),
//        parity_err (result of last frame), err_count (saturating error count, only with
//        PFC_ERR_COUNT_EN defined)
module parity_frame_checker #(
  parameter int FRAME_LEN  = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        x_valid,
  input  logic        x,
  output logic        parity,
  output logic        busy,
  output logic        frame_done,
`ifdef PFC_ERR_COUNT_EN
  output logic [15:0] err_count,
`endif
  output logic        parity_err
);
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);
  state_t           state_q, state_d;
  logic             p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             e;
  assign e          = p_q ^ ODD_PARITY;
  assign busy       = state_q != IDLE;
  assign frame_done = done_q;
  assign parity_err = err_q;
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = err_q;
    parity  = 1'b0;
    case (state_q)
      IDLE: begin
        parity = x_valid & x;
        if (x_valid) begin
          p_d     = x;
          cnt_d   = CNT_W'(1);
          state_d = (FRAME_LEN == 1) ? CHECK : DATA;
        end
      end
      DATA: begin
        parity = p_q ^ (x_valid & x);
        if (x_valid) begin
          p_d     = p_q ^ x;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == LAST) ? CHECK : DATA;
        end
      end
      CHECK: begin
        parity = e;
        if (x_valid) begin
          done_d  = 1'b1;
          err_d   = x != e;
          p_d     = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort wins over any bit consumed this cycle, including the parity bit
    if (clear) begin
      state_d = IDLE;
      p_d     = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      p_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
`ifdef PFC_ERR_COUNT_EN
  logic [15:0] err_count_q;
  assign err_count = err_count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_count_q <= '0;
    else if (done_d && err_d && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
  end
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: scoreboard bench driving an even and an odd parity checker in lockstep
module tb_parity_frame_checker;
  logic clk = 1'b0;
  logic reset_n, clear, x_valid, x;
  logic par_e, busy_e, done_e, err_e;
  logic par_o, busy_o, done_o, err_o;
`ifdef PFC_ERR_COUNT_EN
  logic [15:0] cnt_e, cnt_o;
`endif
  int n_checks = 0;
  int n_fail = 0;
  int m_errcnt = 0;
  logic exp_e[$];
  logic exp_o[$];
  always #5 clk = ~clk;
  parity_frame_checker #(.FRAME_LEN(8), .ODD_PARITY(1'b0), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .x_valid(x_valid), .x(x),
    .parity(par_e), .busy(busy_e), .frame_done(done_e),
`ifdef PFC_ERR_COUNT_EN
    .err_count(cnt_e),
`endif
    .parity_err(err_e)
  );
  parity_frame_checker #(.FRAME_LEN(8), .ODD_PARITY(1'b1), .CNT_W(8)) dut_odd (
    .clk(clk), .reset_n(reset_n), .clear(clear), .x_valid(x_valid), .x(x),
    .parity(par_o), .busy(busy_o), .frame_done(done_o),
`ifdef PFC_ERR_COUNT_EN
    .err_count(cnt_o),
`endif
    .parity_err(err_o)
  );
  // one clock: drive at negedge, check Mealy parity, then pop scoreboard on frame_done after posedge
  task automatic cyc(input logic v, input logic b, input logic clr, input int ep);
    logic w;
    x_valid = v;
    x = b;
    clear = clr;
    #1;
    if (ep >= 0) begin
      n_checks++;
      if (par_e !== ep[0]) begin
        n_fail++;
        $display("FAIL parity: got %b want %0d", par_e, ep);
      end
    end
    @(posedge clk);
    #1;
    if (done_e === 1'b1) begin
      n_checks++;
      if (exp_e.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done_even: got frame_done=1 want 0");
      end else begin
        w = exp_e.pop_front();
        if (w && m_errcnt < 65535) m_errcnt++;
        if (err_e !== w) begin
          n_fail++;
          $display("FAIL err_even: got %b want %b", err_e, w);
        end
      end
    end
    if (done_o === 1'b1) begin
      n_checks++;
      if (exp_o.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done_odd: got frame_done=1 want 0");
      end else begin
        w = exp_o.pop_front();
        if (err_o !== w) begin
          n_fail++;
          $display("FAIL err_odd: got %b want %b", err_o, w);
        end
      end
    end
    @(negedge clk);
  endtask
  // LSB-first frame; sa/sb are data-bit indices followed by 3 stall cycles (-1 for none)
  task automatic send_frame(input logic [7:0] d, input logic r, input int sa, input int sb);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      acc ^= d[i];
      cyc(1'b1, d[i], 1'b0, int'(acc));
      n_checks++;
      if (busy_e !== 1'b1 || done_e !== 1'b0) begin
        n_fail++;
        $display("FAIL data_bit%0d: got busy=%b done=%b want busy=1 done=0", i, busy_e, done_e);
      end
      if (i == sa || i == sb) begin
        repeat (3) begin
          cyc(1'b0, 1'($urandom), 1'b0, int'(acc));
          n_checks++;
          if (busy_e !== 1'b1 || done_e !== 1'b0) begin
            n_fail++;
            $display("FAIL stall: got busy=%b done=%b want busy=1 done=0", busy_e, done_e);
          end
        end
      end
    end
    exp_e.push_back(r != acc);
    exp_o.push_back(r != (acc ^ 1'b1));
    cyc(1'b1, r, 1'b0, int'(acc));
    n_checks++;
    if (busy_e !== 1'b0 || done_e !== 1'b1 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_end: got busy=%b done=%b/%b want busy=0 done=1/1", busy_e, done_e, done_o);
    end
  endtask
  task automatic test_drain(input string name);
    n_checks++;
    if (exp_e.size() != 0 || exp_o.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d/%0d pending want 0/0", name, exp_e.size(), exp_o.size());
      exp_e.delete();
      exp_o.delete();
    end
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    clear = 1'b0;
    x_valid = 1'b0;
    x = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({par_e, busy_e, done_e, err_e, busy_o, done_o, err_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset: got %b want 0000000", {par_e, busy_e, done_e, err_e, busy_o, done_o, err_o});
    end
`ifdef PFC_ERR_COUNT_EN
    n_checks++;
    if (cnt_e !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err_count: got %0d want 0", cnt_e);
    end
`endif
    reset_n = 1'b1;
  endtask
  task automatic test_even_good();
    send_frame(8'h0D, 1'b1, -1, -1);
    n_checks++;
    if (err_e !== 1'b0) begin
      n_fail++;
      $display("FAIL even_good: got err=%b want 0", err_e);
    end
    cyc(1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (done_e !== 1'b0 || err_e !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_len: got done=%b err=%b want 0 0", done_e, err_e);
    end
    test_drain("even_good");
  endtask
  task automatic test_even_bad();
    send_frame(8'h0D, 1'b0, -1, -1);
    n_checks++;
    if (err_e !== 1'b1) begin
      n_fail++;
      $display("FAIL even_bad: got err=%b want 1", err_e);
    end
`ifdef PFC_ERR_COUNT_EN
    n_checks++;
    if (cnt_e !== 16'(m_errcnt)) begin
      n_fail++;
      $display("FAIL err_count: got %0d want %0d", cnt_e, m_errcnt);
    end
`endif
    test_drain("even_bad");
  endtask
  task automatic test_odd();
    send_frame(8'h00, 1'b1, -1, -1);
    n_checks++;
    if (err_o !== 1'b0 || err_e !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_good: got odd=%b even=%b want 0 1", err_o, err_e);
    end
    send_frame(8'h00, 1'b0, -1, -1);
    n_checks++;
    if (err_o !== 1'b1 || err_e !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_bad: got odd=%b even=%b want 1 0", err_o, err_e);
    end
    test_drain("odd");
  endtask
  task automatic test_stall();
    send_frame(8'h0D, 1'b1, 1, 5);
    n_checks++;
    if (err_e !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_result: got err=%b want 0", err_e);
    end
    test_drain("stall");
  endtask
  task automatic test_clear();
    send_frame(8'h01, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, -1);
    n_checks++;
    if (busy_e !== 1'b0 || err_e !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_data: got busy=%b err=%b want 0 1", busy_e, err_e);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, -1);
    cyc(1'b1, 1'b1, 1'b1, 0);
    n_checks++;
    if (busy_e !== 1'b0 || err_e !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_check: got busy=%b err=%b want 0 1", busy_e, err_e);
    end
    send_frame(8'hAA, 1'b0, -1, -1);
    n_checks++;
    if (err_e !== 1'b0) begin
      n_fail++;
      $display("FAIL after_clear: got err=%b want 0", err_e);
    end
    test_drain("clear");
  endtask
  task automatic test_async_reset();
    send_frame(8'h0D, 1'b0, -1, -1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, -1);
    x_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_e, done_e, err_e, busy_o, err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 00000", {busy_e, done_e, err_e, busy_o, err_o});
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_errcnt = 0;
`ifdef PFC_ERR_COUNT_EN
    n_checks++;
    if (cnt_e !== 16'd0) begin
      n_fail++;
      $display("FAIL async_reset_count: got %0d want 0", cnt_e);
    end
`endif
    cyc(1'b0, 1'b0, 1'b0, 0);
    test_drain("async_reset");
  endtask
  task automatic test_back_to_back();
    send_frame(8'hAA, 1'b1, -1, -1);
    send_frame(8'h37, 1'b1, -1, -1);
    send_frame(8'hFE, 1'b1, 2, -1);
    n_checks++;
    if (err_e !== 1'b0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got even=%b odd=%b want 0 1", err_e, err_o);
    end
    test_drain("back_to_back");
  endtask
`ifdef PFC_ERR_COUNT_EN
  task automatic test_err_sat();
    force dut.err_count_q = 16'hFFFD;
    @(posedge clk);
    @(negedge clk);
    release dut.err_count_q;
    m_errcnt = 65533;
    repeat (4) begin
      send_frame(8'h03, 1'b1, -1, -1);
      n_checks++;
      if (cnt_e !== 16'(m_errcnt)) begin
        n_fail++;
        $display("FAIL err_sat: got %h want %h", cnt_e, 16'(m_errcnt));
      end
    end
    n_checks++;
    if (cnt_e !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL err_sat_hold: got %h want ffff", cnt_e);
    end
    test_drain("err_sat");
  endtask
`endif
  initial begin
    test_reset();
    @(negedge clk);
    test_even_good();
    test_even_bad();
    test_odd();
    test_stall();
    test_clear();
    test_async_reset();
    test_back_to_back();
`ifdef PFC_ERR_COUNT_EN
    test_err_sat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Parametrised successor to the single-bit Mealy parity FSM. It consumes a serial bit stream qualified by a valid strobe and groups it into frames of FRAME_LEN data bits followed by one parity bit. It exposes the running parity as a Mealy output, then checks the received parity bit against the even or odd rule. It sits between a serial receiver front end and the frame-level status and error logic.

Parameters:
- FRAME_LEN, default 8: data bits per frame. Legal range is 1..255.
- ODD_PARITY, default 0: 0 selects even parity (data plus parity bit has an even count of ones). 1 selects odd parity.
- CNT_W, default 8: bit-counter width. Must satisfy 2**CNT_W > FRAME_LEN.

Ports:
- clk  in  1  Single system clock, rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- clear  in  1  Synchronous frame abort, active-high.
- x_valid  in  1  Qualifies x. A bit is consumed only when this is high.
- x  in  1  Serial data or parity bit.
- parity  out  1  Mealy running parity, combinational from state, x and x_valid.
- busy  out  1  High when the block is in the DATA or CHECK state.
- frame_done  out  1  Registered one-cycle pulse after the parity bit is consumed.
- parity_err  out  1  Registered result of the last completed frame.
- err_count  out  16  Saturating count of failed frames. Present only with PFC_ERR_COUNT_EN.

Behaviour:
- States are IDLE, DATA and CHECK, held in a state register updated on the clock edge. Next-state and parity are computed in a separate combinational process.
- Internal registers are p (running parity, 1 bit) and cnt (CNT_W bits).
- Reset (reset_n=0, asynchronous):
  - state goes to IDLE; p, cnt, frame_done and parity_err go to 0; err_count goes to 0.
  - Reset asserted mid-frame discards the partial frame with no frame_done.
- IDLE:
  - With x_valid=1: the block consumes data bit 0, sets p to x and cnt to 1.
  - Next state is CHECK if FRAME_LEN==1, otherwise DATA.
  - With x_valid=0: the block stays in IDLE.
- DATA:
  - Each valid bit updates p to p^x and increments cnt.
  - When the bit that makes cnt==FRAME_LEN is consumed, next state is CHECK.
  - x_valid=0 cycles are stalls: no state change and no count.
- CHECK:
  - The next valid bit is the received parity bit r.
  - The expected bit e is p^ODD_PARITY.
  - On consumption: the error result is (r!=e); next state is IDLE; p and cnt clear.
- parity output:
  - In IDLE it is x_valid&x.
  - In DATA it is p^(x_valid&x).
  - In CHECK it is e, independent of x.
- frame_done:
  - Asserts for exactly one cycle, the cycle after the parity bit is consumed.
  - At that same edge parity_err is loaded with the error result.
  - parity_err holds its value until the next frame_done or reset.
- busy is 1 in DATA and CHECK, 0 in IDLE. It is registered-state derived, with no combinational path from x.
- Back-to-back frames: a valid bit arriving on the frame_done cycle is data bit 0 of the next frame. No idle gap is required.
- clear=1:
  - Next state is IDLE; p and cnt clear; no frame_done is generated.
  - parity_err is unchanged.
  - clear has priority over x_valid in the same cycle. That cycle's bit is dropped, even a parity bit in CHECK.
- Latency: the error result is visible 1 clock after the parity bit is accepted.

Optional Feature:
- Macro PFC_ERR_COUNT_EN.
- When defined:
  - The err_count port and its 16-bit register exist.
  - err_count increments at each frame_done with an error result of 1.
  - It saturates at 16'hFFFF without wrapping.
  - It resets to 0 on reset_n only; clear does not affect it.
- When undefined: the port and the register are absent, and all other behaviour is identical.

Test Plan:
- Even parity, FRAME_LEN=8, bits 1,0,1,1,0,0,0,0 then parity bit 1, continuous valid:
  - The parity output sequence is 1,1,0,1,1,1,1,1, then 1 in CHECK.
  - frame_done pulses once the cycle after the parity bit, with parity_err=0.
- Same data with parity bit 0:
  - frame_done with parity_err=1.
  - err_count=1 when PFC_ERR_COUNT_EN is defined.
- ODD_PARITY=1, data 8'h00, parity bit 1:
  - parity_err=0.
  - With parity bit 0 instead, parity_err=1.
- Frame with x_valid=0 inserted after bits 2 and 6 (3 stall cycles each):
  - Same result as the first test.
  - State, p and busy are frozen during the stalls.
- clear asserted after 4 data bits, then a full valid frame AA with parity 0:
  - No frame_done for the aborted frame.
  - The new frame checks cleanly with parity_err=0.
  - reset_n pulsed low mid-frame: outputs return to 0 asynchronously.
- PFC_ERR_COUNT_EN, error counter preloaded near its limit (or 65540 forced bad frames):
  - err_count holds at 16'hFFFF.
